// File: rtl/fib_seq_pkg.sv
// fib_seq_pkg: shared state encoding and default sizes for fib_seq_engine.
// Optional modular mode is enabled with FIB_SEQ_MOD_EN.
package fib_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fib_state_e;

  localparam int FIB_WIDTH = 64;
  localparam int FIB_NW    = 8;

endpackage

// File: rtl/fib_seq_engine_step.sv
// fib_step_add: one sequence step, next = a + b with carry.
// With FIB_SEQ_MOD_EN the sum is reduced once by m (m == 0: no reduction).
module fib_step_add
  import fib_seq_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef FIB_SEQ_MOD_EN
  input  logic [WIDTH-1:0] m_i,
`endif
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH:0] s;

  assign s = {1'b0, a_i} + {1'b0, b_i};

`ifdef FIB_SEQ_MOD_EN
  logic m_zero;
  logic red;

  assign m_zero  = (m_i == '0);
  assign red     = !m_zero && (s >= {1'b0, m_i});
  // s - m < 2**WIDTH when seeds < m, so the low bits are exact
  assign sum_o   = red ? (s[WIDTH-1:0] - m_i) : s[WIDTH-1:0];
  // with reduction active the carry is meaningless, so only m == 0 reports it
  assign carry_o = m_zero & s[WIDTH];
`else
  assign sum_o   = s[WIDTH-1:0];
  assign carry_o = s[WIDTH];
`endif

endmodule

// File: rtl/fib_seq_engine.sv
// fib_seq_engine: request/response engine returning term n of x(i)=x(i-1)+x(i-2).
// FIB_SEQ_MOD_EN adds req_mod and per-step modular reduction.
module fib_seq_engine
  import fib_seq_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int NW    = FIB_NW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [NW-1:0]    req_n,
  input  logic [WIDTH-1:0] req_x0,
  input  logic [WIDTH-1:0] req_x1,
`ifdef FIB_SEQ_MOD_EN
  input  logic [WIDTH-1:0] req_mod,
`endif
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_ovf,
  output logic             busy
);

  fib_state_e       state_q;
  logic [NW-1:0]    n_q;
  logic [NW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             bc_q;
  logic             ovf_q;
  logic [WIDTH-1:0] data_q;
  logic             rovf_q;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;
`ifdef FIB_SEQ_MOD_EN
  logic [WIDTH-1:0] m_q;
`endif

  fib_step_add #(
    .WIDTH(WIDTH)
  ) u_step (
    .a_i    (a_q),
    .b_i    (b_q),
`ifdef FIB_SEQ_MOD_EN
    .m_i    (m_q),
`endif
    .sum_o  (sum_d),
    .carry_o(carry_d)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign resp_data  = data_q;
  assign resp_ovf   = rovf_q;

  // Sequencer: accept, step a/b until cnt reaches n, then hold the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      rovf_q  <= 1'b0;
`ifdef FIB_SEQ_MOD_EN
      m_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            n_q     <= req_n;
            a_q     <= req_x0;
            b_q     <= req_x1;
            cnt_q   <= '0;
            bc_q    <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef FIB_SEQ_MOD_EN
            m_q     <= req_mod;
`endif
            state_q <= RUN;
          end
        end
        RUN: begin
          if (cnt_q == n_q) begin
            data_q  <= a_q;
            rovf_q  <= ovf_q;
            state_q <= DONE;
          end else begin
            // carry of b only counts once b becomes the reported term a
            b_q   <= sum_d;
            bc_q  <= carry_d;
            a_q   <= b_q;
            ovf_q <= ovf_q | bc_q;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
